// File: rtl/node_pkg.sv
// node_pkg: shared types and constants for the node MAC slice.
// FSM encoding, FP constants and small IEEE-754 classifiers.
package node_pkg;
  localparam int N_IN_DEF = 30;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_QBIT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic fp_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic fp_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction
endpackage

// File: rtl/float_adder.sv
// float_adder: combinational IEEE-754 single add, RNE.
// Subnormal operands and results flush to signed zero.
module float_adder
  import node_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              swap;
  logic              sx;
  logic              sy;
  logic              sub;
  logic              far;
  logic              stk;
  logic              rnd;
  logic [30:0]       x;
  logic [30:0]       v;
  logic [7:0]        d;
  logic [26:0]       mx;
  logic [26:0]       my;
  logic [26:0]       sh;
  logic [26:0]       n;
  logic [53:0]       tmp;
  logic [27:0]       s;
  logic [4:0]        lz;
  logic [24:0]       m;
  logic [22:0]       fr;
  logic signed [9:0] e;

  always_comb begin
    swap    = b[30:0] > a[30:0];
    {sx, x} = swap ? b : a;
    {sy, v} = swap ? a : b;
    sub     = sx ^ sy;
    d       = x[30:23] - v[30:23];
    mx      = {1'b1, x[22:0], 3'b000};
    my      = {1'b1, v[22:0], 3'b000};
    tmp     = {my, 27'd0} >> d;
    far     = d > 8'd26;
    sh      = far ? 27'd0 : tmp[53:27];
    stk     = far | (|tmp[26:0]);
    sh[0]   = sh[0] | stk;
    s = sub ? {1'b0, mx} - {1'b0, sh}
            : {1'b0, mx} + {1'b0, sh};
    lz = 5'd0;
    for (int i = 0; i <= 26; i++)
      if (s[i]) lz = 5'(26 - i);
    if (s[27]) begin
      n = s[27:1] | {26'd0, s[0]};
      e = 10'(x[30:23]) + 10'sd1;
    end else begin
      n = s[26:0] << lz;
      e = 10'(x[30:23]) - 10'(lz);
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    m   = {1'b0, n[26:3]} + 25'(rnd);
    if (m[24]) begin
      e  = e + 10'sd1;
      fr = m[23:1];
    end else begin
      fr = m[22:0];
    end
    y = {sx, e[7:0], fr};
    if (e > 10'sd254)
      y = {sx, 8'hFF, 23'd0};
    else if (e < 10'sd1)
      y = {sx, 31'd0};
    if (s == 28'd0)
      y = FP_ZERO;
    if (v[30:23] == 8'h00)
      y = {sx, x};
    // both operands zero: result is -0 only when both are -0
    if (x[30:23] == 8'h00)
      y = {sx & sy, 31'd0};
    if (x[30:23] == 8'hFF)
      y = {sx, x};
    if (fp_inf(a) && fp_inf(b) && sub)
      y = FP_QNAN;
    if (fp_nan(a))
      y = a | FP_QBIT;
    else if (fp_nan(b))
      y = b | FP_QBIT;
  end
endmodule

// File: rtl/float_mult.sv
// float_mult: combinational IEEE-754 single multiply, RNE.
// Subnormal operands and results flush to signed zero.
module float_mult
  import node_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic              sg;
  logic              grd;
  logic              stk;
  logic              rnd;
  logic [47:0]       p;
  logic [22:0]       fr;
  logic [24:0]       m;
  logic signed [9:0] e;

  always_comb begin
    sg = a[31] ^ b[31];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127 + 10'(p[47]);
    if (p[47]) begin
      fr  = p[46:24];
      grd = p[23];
      stk = |p[22:0];
    end else begin
      fr  = p[45:23];
      grd = p[22];
      stk = |p[21:0];
    end
    rnd = grd & (stk | fr[0]);
    m   = {2'b01, fr} + 25'(rnd);
    if (m[24]) begin
      e  = e + 10'sd1;
      fr = m[23:1];
    end else begin
      fr = m[22:0];
    end
    y = {sg, e[7:0], fr};
    if (e > 10'sd254)
      y = {sg, 8'hFF, 23'd0};
    else if (e < 10'sd1)
      y = {sg, 31'd0};
    if (fp_zero(a) || fp_zero(b))
      y = {sg, 31'd0};
    // inf * 0 is invalid; any other inf product keeps the xor sign
    if (fp_inf(a) || fp_inf(b))
      y = (fp_zero(a) || fp_zero(b)) ? FP_QNAN : {sg, 8'hFF, 23'd0};
    if (fp_nan(a))
      y = a | FP_QBIT;
    else if (fp_nan(b))
      y = b | FP_QBIT;
  end
endmodule

// File: rtl/node_mac_dp.sv
// node_mac_dp: shared multiplier/adder with product and sum registers.
// One product is formed per accepted activation and folded in next cycle.
module node_mac_dp
  import node_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        take,
  input  logic        acc_en,
  input  logic [31:0] bias,
  input  logic [31:0] a_data,
  input  logic [31:0] w_data,
  output logic [31:0] acc
);
  logic [31:0] prod;
  logic [31:0] mul_y;
  logic [31:0] add_y;
  logic        prod_v;

  float_mult u_mul (
    .a (a_data),
    .b (w_data),
    .y (mul_y)
  );

  float_adder u_add (
    .a (acc),
    .b (prod),
    .y (add_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= FP_ZERO;
      prod_v <= 1'b0;
      acc    <= FP_ZERO;
    end else if (load) begin
      acc    <= bias;
      prod_v <= 1'b0;
    end else begin
      prod_v <= take;
      if (take)
        prod <= mul_y;
      if (acc_en && prod_v)
        acc <= add_y;
    end
  end
endmodule

// File: rtl/node_mac_seq.sv
// node_mac_seq: sequential neuron, ReLU(bias + sum a_i*w_i).
// Streams N_IN activations through one shared MAC datapath.
module node_mac_seq
  import node_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int AW   = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   bias,
  input  logic          a_valid,
  input  logic [31:0]   a_data,
  output logic          a_ready,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   n_out
);
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] idx;
  logic [31:0]   acc;
  logic          load;
  logic          take;
  logic          last;
  logic          acc_en;

  assign a_ready = state == RUN;
  assign busy    = state != IDLE;
  assign w_addr  = idx;
  assign load    = (state == IDLE) && start;
  assign take    = a_ready && a_valid;
  assign last    = take && (idx == LAST);
  assign acc_en  = (state == RUN) || (state == DRAIN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      n_out <= FP_ZERO;
    end else begin
      state <= state_nx;
      done  <= state == DONE;
      // wrap on the last input so w_addr stays inside the ROM
      if (load)
        idx <= '0;
      else if (take)
        idx <= last ? '0 : idx + 1'b1;
      if (state == DONE)
        n_out <= acc[31] ? FP_ZERO : acc;
    end
  end

  node_mac_dp u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .take   (take),
    .acc_en (acc_en),
    .bias   (bias),
    .a_data (a_data),
    .w_data (w_data),
    .acc    (acc)
  );
endmodule

// File: tb/tb_node_mac_seq.sv
// tb_node_mac_seq: vector table, corner sequences and random runs.
// Expected results come from integer arithmetic on exact FP values.
module tb_node_mac_seq;
  localparam int N = 30;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] b;
    int          mode;
    int          poke;
    logic [31:0] expv;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [31:0]          bias;
  logic                 a_valid;
  logic [31:0]          a_data;
  logic                 a_ready;
  logic [$clog2(N)-1:0] w_addr;
  logic [31:0]          w_data;
  logic                 busy;
  logic                 done;
  logic [31:0]          n_out;

  logic [31:0] abits [N];
  logic [31:0] wrom  [N];
  vec_t        tbl   [10];
  int          applied = 0;
  int          miss = 0;

  always #5 clk = ~clk;

  assign w_data = (int'(w_addr) < N) ? wrom[w_addr] : 32'hDEAD_BEEF;

  node_mac_seq #(.N_IN(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bias    (bias),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .busy    (busy),
    .done    (done),
    .n_out   (n_out)
  );

  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    logic [31:0] t;
    int          e;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    e = 31;
    while (!m[e]) e--;
    t = m << (23 - e);
    return {v < 0, 8'(127 + e), t[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] b,
                     input int mode, input int poke, input int rst_at,
                     input bit pre, input bit chain,
                     input logic [31:0] expv);
    int cnt, cyc, acc_cyc, done_cyc, ndone;
    if (!pre) begin
      @(negedge clk);
      bias  = b;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    bias  = $urandom;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    cnt = 0; cyc = 0; acc_cyc = -100; done_cyc = -1; ndone = 0;
    while (cyc < 400 && (acc_cyc < 0 || cyc <= acc_cyc + 5)) begin
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (rst_at >= 0 && cnt == rst_at) begin
        rst_n   = 1'b0;
        a_valid = 1'b0;
        #1;
        chk({nm, " rst busy"}, 32'(busy), 32'd0);
        chk({nm, " rst done"}, 32'(done), 32'd0);
        chk({nm, " rst ready"}, 32'(a_ready), 32'd0);
        chk({nm, " rst waddr"}, 32'(w_addr), 32'd0);
        chk({nm, " rst n_out"}, n_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (poke >= 0) && (cnt == poke);
      if (chain && done) begin
        start = 1'b1;
        bias  = b;
      end
      case (mode)
        0:       a_valid = cnt < N;
        1:       a_valid = (cnt < N) && (cyc % 2 == 0);
        default: a_valid = (cnt < N) && ($urandom_range(0, 2) != 0);
      endcase
      a_data = a_valid ? abits[cnt] : $urandom;
      if (a_valid && a_ready) begin
        chk({nm, " w_addr"}, 32'(w_addr), cnt);
        cnt++;
        if (cnt == N) acc_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    a_valid = 1'b0;
    start   = 1'b0;
    chk({nm, " accepts"}, cnt, N);
    chk({nm, " done count"}, ndone, 1);
    chk({nm, " done latency"}, done_cyc - acc_cyc, 3);
    chk({nm, " n_out"}, n_out, expv);
    chk({nm, " busy end"}, 32'(busy), 32'(chain));
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] w);
    foreach (abits[i]) begin
      abits[i] = a;
      wrom[i]  = w;
    end
  endtask

  initial begin
    tbl[0] = '{"ones", 32'h3F800000, 32'h3F800000, 32'h0, 0, -1,
               32'h41F00000};
    tbl[1] = '{"neg", 32'h3F800000, 32'hBF800000, 32'h0, 0, -1,
               32'h00000000};
    tbl[2] = '{"toggle", 32'h3F800000, 32'h3F800000, 32'h0, 1, -1,
               32'h41F00000};
    tbl[3] = '{"zero act", 32'h00000000, 32'h3F800000, 32'h3D447F3D,
               0, -1, 32'h3D447F3D};
    tbl[4] = '{"start poke", 32'h3F800000, 32'h3F800000, 32'h0, 0, 5,
               32'h41F00000};
    tbl[5] = '{"half", 32'h40000000, 32'h3F000000, 32'h3F800000, 2,
               -1, 32'h41F80000};
    tbl[6] = '{"bias40", 32'hBF800000, 32'h3F800000, 32'h42200000, 1,
               -1, 32'h41200000};
    tbl[7] = '{"pinf", 32'h3F800000, 32'h7F800000, 32'h0, 0, -1,
               32'h7F800000};
    tbl[8] = '{"ninf", 32'h3F800000, 32'hFF800000, 32'h0, 2, -1,
               32'h00000000};
    tbl[9] = '{"negzero", 32'h00000000, 32'h3F800000, 32'h80000000, 0,
               -1, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; bias = '0;
    a_valid = 1'b0; a_data = '0;
    fill(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ready", 32'(a_ready), 32'd0);
    chk("reset waddr", 32'(w_addr), 32'd0);
    chk("reset n_out", n_out, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      fill(tbl[k].a, tbl[k].w);
      run(tbl[k].nm, tbl[k].b, tbl[k].mode, tbl[k].poke, -1,
          1'b0, 1'b0, tbl[k].expv);
    end

    fill(32'h3F800000, 32'h3F800000);
    run("chain1", 32'h0, 0, -1, -1, 1'b0, 1'b1, 32'h41F00000);
    run("chain2", 32'h0, 1, -1, -1, 1'b1, 1'b0, 32'h41F00000);
    run("midreset", 32'h0, 0, -1, 10, 1'b0, 1'b0, 32'h0);
    run("after rst", 32'h0, 0, -1, -1, 1'b0, 1'b0, 32'h41F00000);

    for (int r = 0; r < 12; r++) begin
      int sum, av, wv;
      logic [31:0] bb;
      sum = int'($urandom_range(0, 100)) - 20;
      bb  = i2f(sum);
      for (int i = 0; i < N; i++) begin
        av = int'($urandom_range(0, 16)) - 8;
        wv = int'($urandom_range(0, 16)) - 8;
        abits[i] = i2f(av);
        wrom[i]  = i2f(wv);
        sum += av * wv;
      end
      run("rand", bb, int'($urandom_range(0, 2)), -1, -1, 1'b0, 1'b0,
          (sum < 0) ? 32'h0 : i2f(sum));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end
endmodule

// File: doc/node_mac_seq.md
NODE_MAC_SEQ -- requirements
Module: node_mac_seq

Interface
REQ-001 SHALL have parameter N_IN, default 30, number of inputs per neuron (2..64).
REQ-002 SHALL have parameter AW, default $clog2(N_IN), width of the weight address.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one neuron evaluation; sampled in IDLE only.
REQ-006 SHALL have port bias  input  32  IEEE-754 single bias; sampled on the accepted start.
REQ-007 SHALL have port a_valid  input  1  activation stream valid.
REQ-008 SHALL have port a_data  input  32  IEEE-754 single activation.
REQ-009 SHALL have port a_ready  output  1  activation accepted when a_valid and a_ready are both high.
REQ-010 SHALL have port w_addr  output  AW  weight ROM address, equal to the current input index.
REQ-011 SHALL have port w_data  input  32  weight for w_addr, combinational read, valid in the same cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse, n_out updated.
REQ-014 SHALL have port n_out  output  32  ReLU(bias + sum of a_i*w_i), held until the next done.

Function
REQ-015 SHALL time-share one float_mult and one float_adder across all N_IN products.
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on the handshake for index N_IN-1; DRAIN->DONE and DONE->IDLE unconditionally.
REQ-017 SHALL, on the accepted start, load acc<=bias, idx<=0, prod_v<=0.
REQ-018 SHALL drive a_ready high only in RUN; stalls (a_valid low) SHALL freeze idx and consume no weight.
REQ-019 SHALL, per RUN handshake, register prod<=a_data*w_data, set prod_v<=1, and increment idx; without a handshake, prod_v<=0.
REQ-020 SHALL, in RUN and DRAIN, update acc<=acc+prod when prod_v=1; otherwise hold acc.
REQ-021 SHALL, in DONE, register n_out<=0 if acc[31]=1 (including -0.0), else n_out<=acc, and register done<=1 for exactly one cycle.
REQ-022 SHALL assert done two clock edges after the edge that accepts the last activation.
REQ-023 SHALL ignore start while busy=1; start in the cycle in which done is high SHALL be accepted.
REQ-024 SHALL hold w_addr=idx; w_addr SHALL never exceed N_IN-1.
REQ-025 SHALL pass IEEE special values through the shared units unmodified; only the ReLU sign rule applies.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state=IDLE, idx=0, acc=0, prod=0, prod_v=0, done=0, n_out=0, a_ready=0, busy=0.
REQ-027 SHALL, on reset mid-evaluation, discard the partial sum and require a new start.

Structure
REQ-028 SHALL place the state enum, FP_ZERO (32'h0) and the N_IN default in a shared package, node_pkg.
REQ-029 SHALL use one sub-module, node_mac_dp: mult/adder instances plus the prod, prod_v and acc registers. The FSM SHALL remain in node_mac_seq.

Verification
REQ-030 SHALL check: all A=1.0 (3F800000), all W=1.0, bias=0, a_valid always high -> n_out=41F00000 (30.0); done 2 edges after the 30th accept.
REQ-031 SHALL check: all A=1.0, all W=-1.0 (BF800000), bias=0 -> acc=-30.0, n_out=00000000, done pulses once.
REQ-032 SHALL check: the REQ-030 stimulus with a_valid toggling every other cycle -> same n_out; w_addr sequence 0..29 with no skips.
REQ-033 SHALL check: all A=0, bias=3D447F3D -> n_out=3D447F3D.
REQ-034 SHALL check: start pulsed at idx=5 while busy -> ignored; a single done; result unchanged.
REQ-035 SHALL check: rst_n low at idx=10 -> all outputs 0, IDLE; a following REQ-030 run -> 41F00000.
